// File: rtl/outr_serial_tx_if.sv
// Handshake bundle between the OUTR/FGO side of the CPU and the serial
// transmitter: the character, the OUT request pulse and the status flags.
interface outr_serial_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] outr_data;
  logic                  fgo_clr;
  logic                  fgo;
  logic                  busy;
  logic                  ovr;

  // CPU side drives the character and request, reads back the flags
  modport master (
    output outr_data,
    output fgo_clr,
    input  fgo,
    input  busy,
    input  ovr
  );

  // Transmitter side consumes the request and reports status
  modport slave (
    input  outr_data,
    input  fgo_clr,
    output fgo,
    output busy,
    output ovr
  );
endinterface

// File: rtl/outr_serial_tx.sv
// OUTR serial transmitter: accepts a character on fgo_clr while fgo=1 and
// sends it as start bit, DATA_WIDTH data bits LSB first, then STOP_BITS stop
// bits, each held CLKS_PER_BIT clocks. fgo drops for the whole frame and a
// request that arrives while fgo=0 only raises the sticky ovr flag.
// CLKS_PER_BIT must be at least 2 and STOP_BITS is 1 or 2.
module outr_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  outr_serial_tx_if.slave     bus,
  output logic                tx_line
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      baud_cnt, baud_next;
  logic [IDX_W-1:0]      bit_idx, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  fgo_q, fgo_next;
  logic                  tx_q, tx_next;
  logic                  ovr_q, ovr_next;

  logic accept;
  logic terminal;
  logic last_data;
  logic last_stop;

  // fgo_clr is qualified with the registered fgo, so a request on the same
  // edge that fgo rises still counts as an overrun, not an accept
  assign accept    = (state == IDLE) && fgo_q && bus.fgo_clr;
  assign terminal  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));

  assign tx_line  = tx_q;
  assign bus.fgo  = fgo_q;
  assign bus.ovr  = ovr_q;
  assign bus.busy = (state != IDLE);

  // State, datapath and registered outputs; reset abandons any frame at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      fgo_q     <= 1'b1;
      tx_q      <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= idx_next;
      shift_reg <= shift_next;
      fgo_q     <= fgo_next;
      tx_q      <= tx_next;
      ovr_q     <= ovr_next;
    end
  end

  // Next state plus baud counter, bit/stop index and shift register updates
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          baud_next  = '0;
          idx_next   = '0;
          shift_next = bus.outr_data;
        end
      end
      START: begin
        if (terminal) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (terminal) begin
          baud_next = '0;
          if (last_data) begin
            state_next = STOP;
            idx_next   = '0;
          end else begin
            shift_next = shift_reg >> 1;
            idx_next   = bit_idx + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (terminal) begin
          baud_next = '0;
          if (last_stop) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = bit_idx + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs tx_line, fgo and ovr
  always_comb begin
    fgo_next = fgo_q;
    tx_next  = tx_q;
    ovr_next = ovr_q;
    if (bus.fgo_clr && !fgo_q) begin
      ovr_next = 1'b1;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          fgo_next = 1'b0;
          tx_next  = 1'b0;
          ovr_next = 1'b0;
        end
      end
      START: begin
        if (terminal) begin
          tx_next = shift_reg[0];
        end
      end
      DATA: begin
        if (terminal) begin
          tx_next = last_data ? 1'b1 : shift_next[0];
        end
      end
      STOP: begin
        if (terminal && last_stop) begin
          fgo_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_outr_serial_tx.sv
// Directed bench for outr_serial_tx: expected line levels are queued per
// clock when a character is requested and popped one per clock as the DUT
// shifts it out. Instance a uses 4 clk/bit, 1 stop; instance b 2 clk/bit, 2 stop.
module tb_outr_serial_tx;

  logic clk;
  logic reset;
  logic tx_a;
  logic tx_b;

  int checks;
  int errors;
  int edge_no;

  logic exp_q[$];

  outr_serial_tx_if #(.DATA_WIDTH(8)) bus_a ();
  outr_serial_tx_if #(.DATA_WIDTH(8)) bus_b ();

  outr_serial_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .tx_line(tx_a)
  );

  outr_serial_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(2), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .tx_line(tx_b)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_tx(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic get_fgo(input int which);
    return (which != 0) ? bus_b.fgo : bus_a.fgo;
  endfunction

  function automatic logic get_busy(input int which);
    return (which != 0) ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic get_ovr(input int which);
    return (which != 0) ? bus_b.ovr : bus_a.ovr;
  endfunction

  task automatic set_clr(input int which, input logic v);
    if (which != 0) bus_b.fgo_clr = v;
    else bus_a.fgo_clr = v;
  endtask

  task automatic set_data(input int which, input logic [7:0] v);
    if (which != 0) bus_b.outr_data = v;
    else bus_a.outr_data = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for every clock of one frame, starting at the accept edge
  task automatic push_frame(input int which, input logic [7:0] data);
    int cpb;
    int sb;
    cpb = (which != 0) ? 2 : 4;
    sb  = (which != 0) ? 2 : 1;
    repeat (cpb) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (cpb) exp_q.push_back(data[b]);
    end
    repeat (sb * cpb) exp_q.push_back(1'b1);
  endtask

  task automatic pop_check(input int which);
    logic e;
    if (exp_q.size() == 0) begin
      check_output("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_output($sformatf("tx_%0d_e%0d", which, edge_no), {31'd0, get_tx(which)}, {31'd0, e});
    end
  endtask

  // Request a character; the accepting edge becomes edge 0
  task automatic apply_stimulus(input int which, input logic [7:0] data, input bit hold);
    set_data(which, data);
    set_clr(which, 1'b1);
    push_frame(which, data);
    tick();
    edge_no = 0;
    if (!hold) set_clr(which, 1'b0);
    pop_check(which);
    check_output("accept_fgo",  {31'd0, get_fgo(which)},  32'd0);
    check_output("accept_busy", {31'd0, get_busy(which)}, 32'd1);
    check_output("accept_ovr",  {31'd0, get_ovr(which)},  32'd0);
  endtask

  // Advance n clocks comparing the line against the queue; optionally pulse
  // an overrun request at one edge or scramble outr_data every clock
  task automatic drain(input int which, input int n, input int ovr_edge,
                       input logic [7:0] ovr_data, input bit scramble);
    bit pulse;
    for (int k = 0; k < n; k++) begin
      pulse = (edge_no + 1 == ovr_edge);
      if (pulse) begin
        set_clr(which, 1'b1);
        set_data(which, ovr_data);
      end else if (scramble) begin
        set_data(which, 8'($urandom));
      end
      tick();
      if (pulse) set_clr(which, 1'b0);
      pop_check(which);
    end
  endtask

  // Last stop clock still busy, next edge returns to ready/idle
  task automatic check_frame_end(input int which, input int frame_len);
    check_output("pre_end_fgo", {31'd0, get_fgo(which)}, 32'd0);
    tick();
    check_output("end_edge",  edge_no,                     frame_len);
    check_output("end_fgo",   {31'd0, get_fgo(which)},  32'd1);
    check_output("end_busy",  {31'd0, get_busy(which)}, 32'd0);
    check_output("end_tx",    {31'd0, get_tx(which)},   32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edge_no = 0;
    reset   = 1'b0;
    bus_a.fgo_clr = 1'b0;
    bus_a.outr_data = 8'h00;
    bus_b.fgo_clr = 1'b0;
    bus_b.outr_data = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_fgo_a",  {31'd0, bus_a.fgo},  32'd1);
    check_output("rst_tx_a",   {31'd0, tx_a},       32'd1);
    check_output("rst_busy_a", {31'd0, bus_a.busy}, 32'd0);
    check_output("rst_ovr_a",  {31'd0, bus_a.ovr},  32'd0);
    check_output("rst_fgo_b",  {31'd0, bus_b.fgo},  32'd1);
    check_output("rst_tx_b",   {31'd0, tx_b},       32'd1);
    reset = 1'b1;
    tick();

    $display("[TB] single frame A5 with overrun FF at edge 12");
    apply_stimulus(0, 8'hA5, 1'b0);
    drain(0, exp_q.size(), 12, 8'hFF, 1'b0);
    check_output("ovr_set", {31'd0, bus_a.ovr}, 32'd1);
    check_frame_end(0, 40);

    $display("[TB] accept 3C clears overrun");
    apply_stimulus(0, 8'h3C, 1'b0);
    drain(0, exp_q.size(), -1, 8'h00, 1'b0);
    check_frame_end(0, 40);

    $display("[TB] back-to-back 00 then FF with fgo_clr held");
    apply_stimulus(0, 8'h00, 1'b1);
    exp_q.push_back(1'b1);
    push_frame(0, 8'hFF);
    set_data(0, 8'hFF);
    drain(0, 1, -1, 8'h00, 1'b0);
    check_output("b2b_ovr_busy", {31'd0, bus_a.ovr}, 32'd1);
    drain(0, 39, -1, 8'h00, 1'b0);
    check_output("b2b_gap_fgo", {31'd0, bus_a.fgo},  32'd1);
    check_output("b2b_gap_busy", {31'd0, bus_a.busy}, 32'd0);
    check_output("b2b_gap_ovr", {31'd0, bus_a.ovr},  32'd1);
    drain(0, 1, -1, 8'h00, 1'b0);
    check_output("b2b_acc2_ovr", {31'd0, bus_a.ovr}, 32'd0);
    check_output("b2b_acc2_fgo", {31'd0, bus_a.fgo}, 32'd0);
    drain(0, exp_q.size(), -1, 8'h00, 1'b0);
    set_clr(0, 1'b0);
    check_frame_end(0, 81);
    check_output("b2b_end_ovr", {31'd0, bus_a.ovr}, 32'd1);

    $display("[TB] data stability 5A with outr_data scrambled");
    apply_stimulus(0, 8'h5A, 1'b0);
    drain(0, exp_q.size(), -1, 8'h00, 1'b1);
    check_frame_end(0, 40);

    $display("[TB] reset during data bit 3");
    apply_stimulus(0, 8'hA5, 1'b0);
    drain(0, 17, 5, 8'h77, 1'b0);
    check_output("pre_rst_ovr", {31'd0, bus_a.ovr}, 32'd1);
    exp_q.delete();
    reset = 1'b0;
    #1;
    check_output("async_rst_tx",   {31'd0, tx_a},       32'd1);
    check_output("async_rst_fgo",  {31'd0, bus_a.fgo},  32'd1);
    check_output("async_rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check_output("async_rst_ovr",  {31'd0, bus_a.ovr},  32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_output($sformatf("post_rst_tx_%0d", k), {31'd0, tx_a}, 32'd1);
    end
    check_output("post_rst_busy", {31'd0, bus_a.busy}, 32'd0);

    $display("[TB] two stop bits, 2 clk/bit, data 01");
    apply_stimulus(1, 8'h01, 1'b0);
    drain(1, exp_q.size(), -1, 8'h00, 1'b0);
    check_frame_end(1, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/outr_serial_tx.md
Name: outr_serial_tx

Overview:
- Output-side transmitter for the Basic Computer character output path.
- Takes the parallel OUTR byte and shifts it out as a UART-style frame on a single serial line: start bit, then data bits LSB first, then stop bit(s).
- Drives the FGO output-ready flag, the other end of the FGO/OUTR handshake the CPU uses for the OUT and SKO instructions.
- Sits between the OUTR register and the external tx pin.

Parameters:
- DATA_WIDTH, 8: data bits per frame, equal to the OUTR width.
- CLKS_PER_BIT, 16: clk cycles per serial bit period; minimum 2.
- STOP_BITS, 1: number of stop bits per frame; 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- outr_data  input  DATA_WIDTH  parallel character from OUTR; sampled only on the accepting edge.
- fgo_clr  input  1  one-cycle pulse from the CPU OUT instruction requesting transmission of outr_data.
- fgo  output  1  output flag; 1 = transmitter ready for a new character (SKO sees this).
- tx_line  output  1  serial output; idle level 1.
- busy  output  1  1 while a frame is in progress (state other than IDLE).
- ovr  output  1  sticky overrun flag; set when fgo_clr arrives while fgo=0.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE, fgo=1, tx_line=1, busy=0, ovr=0.
  - Bit counter, baud counter and shift register are cleared.
  - A frame in progress is abandoned immediately; the line returns to 1 with no partial stop bit.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- Accept:
  - In IDLE with fgo=1, fgo_clr=1 at edge n does all of the following at edge n:
    - latches outr_data into the shift register;
    - sets fgo to 0, tx_line to 0 and busy to 1;
    - clears ovr;
    - enters START with the baud counter at 0.
- Bit timing:
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At the terminal count it resets to 0 and the next bit is driven.
- START: after CLKS_PER_BIT cycles, tx_line = shift[0] and the state moves to DATA with bit index 0.
- DATA:
  - At each terminal count the shift register shifts right and the bit index increments.
  - After bit DATA_WIDTH-1 has been held for its full period, tx_line=1 and the state moves to STOP.
- STOP:
  - tx_line is held at 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final terminal count: state=IDLE, busy=0, fgo=1.
- Frame length:
  - fgo returns to 1 exactly (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles after the accepting edge n.
  - tx_line is low from edge n to edge n+CLKS_PER_BIT (start bit).
- Back-to-back:
  - fgo_clr is qualified with the registered fgo, so the earliest new accept is the edge after fgo returns to 1.
  - Consequence: the minimum gap between frames is 1 clk of idle-high.
- Overrun:
  - fgo_clr while fgo=0 (busy) is ignored: no data latch and no effect on the current frame.
  - It sets ovr=1, which stays set until reset or the next accepted fgo_clr.
- outr_data changes after the accept edge have no effect on the frame in progress.
- fgo_clr held high for several cycles in IDLE counts as one accept. The following cycles fall in the busy window and set ovr.

Test Plan:
- Reset check: assert reset=0 mid-frame (DATA bit 3) with CLKS_PER_BIT=4 -> same cycle tx_line=1, fgo=1, busy=0, ovr=0; after release the line stays 1 indefinitely.
- Single frame: CLKS_PER_BIT=4, STOP_BITS=1, outr_data=8'hA5, pulse fgo_clr at edge 0.
  - tx_line: 0 for edges 0-3, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - fgo=1 at edge 40.
- Overrun: during the 8'hA5 frame, pulse fgo_clr with outr_data=8'hFF at edge 12 -> ovr=1, frame bits unchanged, fgo still rises at edge 40.
  - A subsequent accept with 8'h3C clears ovr.
- Back-to-back: fgo_clr held continuously high with outr_data=8'h00 then 8'hFF -> two complete frames, separated by exactly 1 idle-high cycle; ovr=1 after the first accept.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=2, outr_data=8'h01 -> stop level lasts 4 cycles; fgo returns at edge 22.
- Data stability: change outr_data every cycle after accepting 8'h5A -> serialized bits are exactly 0,1,0,1,1,0,1,0.
